// File: rtl/video_pattern_generator_pkg.sv
// Shared definitions for the video pattern generator: pattern modes, bar colours, CLOG2 helper macro.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package video_pattern_generator_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Colour bars left to right: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/video_pattern_generator_timing_counter.sv
// Raster timing for a two-cycles-per-pixel source: sub/h/v counters, frame-start, line-wrap and active flags.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module video_timing_counter #(
    parameter int H_ACTIVE = 24,
    parameter int H_TOTAL  = 38,
    parameter int V_ACTIVE = 16,
    parameter int V_TOTAL  = 30,
    parameter int HW       = `CLOG2(H_TOTAL),
    parameter int VW       = `CLOG2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          sub,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          frame_start,
    output logic          line_wrap,
    output logic          active
);

    logic          sub_q, sub_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    always_comb begin
        sub_d = ~sub_q;
        h_d   = h_q;
        v_d   = v_q;
        if (sub_q) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            sub_q <= 1'b0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            sub_q <= sub_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign sub         = sub_q;
    assign h           = h_q;
    assign v           = v_q;
    assign frame_start = !sub_q && (h_q == '0) && (v_q == '0);
    assign line_wrap   = sub_q && (h_q == HW'(H_TOTAL - 1));
    assign active      = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));

endmodule

// File: rtl/video_pattern_generator.sv
// Test-pattern source for the DVI transmit path: pixel timing plus bars/gradient/checker/solid RGB.
// Define PATTERN_SCROLL_EN to scroll bars, gradient and checker one pixel left per frame.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module video_pattern_generator
    import video_pattern_generator_pkg::*;
#(
    parameter int H_ACTIVE     = 24,
    parameter int H_TOTAL      = 38,
    parameter int V_ACTIVE     = 16,
    parameter int V_TOTAL      = 30,
    parameter int CHECKER_SIZE = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic [1:0]  iMode,
    input  logic [23:0] iSolidRgb,
    output logic        oPixelSync,
    output logic        oPixelActive,
    output logic [7:0]  oDataRed,
    output logic [7:0]  oDataGreen,
    output logic [7:0]  oDataBlue
);

    localparam int HW    = `CLOG2(H_TOTAL);
    localparam int VW    = `CLOG2(V_TOTAL);
    localparam int CW    = `CLOG2(CHECKER_SIZE + 1);
    localparam int BAR_W = (H_ACTIVE / 8 >= 1) ? H_ACTIVE / 8 : 1;

    logic          clr;
    logic          sub, frame_start, line_wrap, frame_wrap, active;
    logic [HW-1:0] h, x;
    logic [VW-1:0] v;

    assign clr = iRst || !iEnable;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(iClk), .rst(iRst), .en(iEnable),
        .sub(sub), .h(h), .v(v),
        .frame_start(frame_start), .line_wrap(line_wrap), .active(active)
    );

    assign frame_wrap = line_wrap && (v == VW'(V_TOTAL - 1));

    // Checker cells tracked with modulo counters: c = position inside a cell, p = cell parity
    logic [CW-1:0] xc_q, xc_d, yc_q, yc_d, seed_c;
    logic          xp_q, xp_d, yp_q, yp_d, seed_p;
    mode_e         mode_q, mode_d, mode_eff;
    logic [23:0]   solid_q, solid_d, solid_eff, rgb, rgb_q, rgb_d;
    logic          sync_q, sync_d, active_q, active_d;
    logic [2:0]    bar;

`ifdef PATTERN_SCROLL_EN
    logic [HW-1:0] x_q, x_d, off_q, off_d;
    logic [CW-1:0] offc_q, offc_d;
    logic          offp_q, offp_d;
    assign x = x_q;
`else
    assign x = h;
`endif

    function automatic logic [CW:0] cell_step(input logic [CW-1:0] c, input logic p);
        if (c == CW'(CHECKER_SIZE - 1)) return {CW'(0), ~p};
        return {c + 1'b1, p};
    endfunction

    always_comb begin
        xc_d   = xc_q;
        xp_d   = xp_q;
        yc_d   = yc_q;
        yp_d   = yp_q;
        seed_c = '0;
        seed_p = 1'b0;
`ifdef PATTERN_SCROLL_EN
        x_d    = x_q;
        off_d  = off_q;
        offc_d = offc_q;
        offp_d = offp_q;
        if (frame_wrap) begin
            if (off_q == HW'(H_ACTIVE - 1)) begin
                off_d  = '0;
                offc_d = '0;
                offp_d = 1'b0;
            end else begin
                off_d = off_q + 1'b1;
                {offc_d, offp_d} = cell_step(offc_q, offp_q);
            end
        end
        seed_c = offc_d;
        seed_p = offp_d;
        if (line_wrap)
            x_d = off_d;
        else if (sub)
            x_d = (x_q == HW'(H_ACTIVE - 1)) ? '0 : x_q + 1'b1;
`endif
        if (line_wrap) begin
            xc_d = seed_c;
            xp_d = seed_p;
            if (frame_wrap) begin
                yc_d = '0;
                yp_d = 1'b0;
            end else begin
                {yc_d, yp_d} = cell_step(yc_q, yp_q);
            end
        end else if (sub) begin
            if (x == HW'(H_ACTIVE - 1)) begin
                xc_d = '0;
                xp_d = 1'b0;
            end else begin
                {xc_d, xp_d} = cell_step(xc_q, xp_q);
            end
        end
    end

    // Pattern select; mode and solid colour change only on the first cycle of a frame
    always_comb begin
        mode_eff  = frame_start ? mode_e'(iMode) : mode_q;
        solid_eff = frame_start ? iSolidRgb : solid_q;
        mode_d    = mode_eff;
        solid_d   = solid_eff;
        bar       = '0;
        for (int k = 1; k < 8; k++)
            if (x >= HW'(k * BAR_W)) bar = 3'(k);
        case (mode_eff)
            MODE_BARS:  rgb = BAR_RGB[bar];
            MODE_GRAD:  rgb = {3{8'(x)}};
            MODE_CHECK: rgb = (xp_q ^ yp_q) ? 24'h000000 : 24'hFFFFFF;
            default:    rgb = solid_eff;
        endcase
        sync_d   = frame_start;
        active_d = active;
        rgb_d    = active ? rgb : 24'h000000;
    end

    always_ff @(posedge iClk) begin
        if (clr) begin
            sync_q   <= 1'b0;
            active_q <= 1'b0;
            rgb_q    <= '0;
            mode_q   <= mode_e'(iMode);
            solid_q  <= iSolidRgb;
            xc_q     <= '0;
            xp_q     <= 1'b0;
            yc_q     <= '0;
            yp_q     <= 1'b0;
`ifdef PATTERN_SCROLL_EN
            x_q      <= '0;
            off_q    <= '0;
            offc_q   <= '0;
            offp_q   <= 1'b0;
`endif
        end else begin
            sync_q   <= sync_d;
            active_q <= active_d;
            rgb_q    <= rgb_d;
            mode_q   <= mode_d;
            solid_q  <= solid_d;
            xc_q     <= xc_d;
            xp_q     <= xp_d;
            yc_q     <= yc_d;
            yp_q     <= yp_d;
`ifdef PATTERN_SCROLL_EN
            x_q      <= x_d;
            off_q    <= off_d;
            offc_q   <= offc_d;
            offp_q   <= offp_d;
`endif
        end
    end

    assign oPixelSync   = sync_q;
    assign oPixelActive = active_q;
    assign oDataRed     = rgb_q[23:16];
    assign oDataGreen   = rgb_q[15:8];
    assign oDataBlue    = rgb_q[7:0];

endmodule
